func_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for the 2-input boolean function unit `func` (ports sel[3:0], a, b → z).
- Drives sel/a/b through all 64 vectors, or the 4 vectors of one selected function. Samples z after a programmable settle delay and compares it against the golden truth table.
- Reports pass/fail, error count and the first failing vector.
- Sits beside the `func` instance and owns its inputs while busy.

---
 rtl/func_pkg.sv | 24 ++
 rtl/func_bist_ctrl.sv | 135 +++++++++++++
 tb/tb_func_bist_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/func_pkg.sv
// Shared types and golden model for the func unit BIST sequencer.
// func_expect is the reference truth table: z is bit {a,b} of sel.
package func_pkg;

   localparam int SEL_W       = 4;
   localparam int VEC_W       = 6;
   localparam int FULL_LAST   = 63;
   localparam int SINGLE_LAST = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      FIN   = 3'd4
   } state_t;

   function automatic logic func_expect(input logic [SEL_W-1:0] sel,
                                        input logic a,
                                        input logic b);
      return sel[{a, b}];
   endfunction

endpackage

// File: rtl/func_bist_ctrl.sv
// BIST sequencer for the func unit: sweeps all 64 {sel,a,b} vectors (or the
// 4 vectors of one function), samples f_z after a settle delay, logs errors.
module func_bist_ctrl
   import func_pkg::*;
#(
   parameter int SETTLE_CYC = 1,
   parameter int ERR_W      = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             single,
   input  logic [SEL_W-1:0] single_sel,
   output logic [SEL_W-1:0] f_sel,
   output logic             f_a,
   output logic             f_b,
   input  logic             f_z,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [VEC_W-1:0] fail_vec,
   output state_t           dbg_state
);

   localparam int WCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [VEC_W-1:0] idx;
   logic [WCW-1:0]   wcnt;
   logic             lat_single;
   logic [SEL_W-1:0] lat_sel;
   logic             last_vec;
   logic             settled;
   logic             mismatch;
   logic             abort_run;

   // Run handshake: start is sampled only while idle (ignored if abort is also
   // high); busy covers the whole run through FIN; done pulses once in FIN and
   // never appears for an aborted run.
   assign busy      = (state != IDLE);
   assign done      = (state == FIN);
   assign dbg_state = state;

   assign abort_run = abort && (state != IDLE);
   assign last_vec  = lat_single ? (idx == VEC_W'(SINGLE_LAST))
                                 : (idx == VEC_W'(FULL_LAST));
   assign settled   = (wcnt == WCW'(SETTLE_CYC - 1));
   assign mismatch  = (f_z != func_expect(f_sel, f_a, f_b));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !abort) state_nxt = DRIVE;
         DRIVE:   state_nxt = (SETTLE_CYC > 0) ? WAIT : CHECK;
         WAIT:    if (settled) state_nxt = CHECK;
         CHECK:   state_nxt = last_vec ? FIN : DRIVE;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort_run) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         wcnt       <= '0;
         lat_single <= 1'b0;
         lat_sel    <= '0;
         f_sel      <= '0;
         f_a        <= 1'b0;
         f_b        <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
      end else if (abort_run) begin
         // Partial error log is kept for post-mortem; only the verdict drops.
         pass <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  idx        <= '0;
                  lat_single <= single;
                  lat_sel    <= single_sel;
                  pass       <= 1'b0;
                  err_cnt    <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
               end
            end
            DRIVE: begin
               wcnt <= '0;
               if (lat_single) begin
                  f_sel        <= lat_sel;
                  {f_a, f_b}   <= idx[1:0];
               end else begin
                  {f_sel, f_a, f_b} <= idx;
               end
            end
            WAIT: begin
               wcnt <= wcnt + WCW'(1);
            end
            CHECK: begin
               if (mismatch) begin
                  if (!(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
                  if (!fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_vec   <= {f_sel, f_a, f_b};
                  end
               end
               if (last_vec) begin
                  pass <= (err_cnt == '0) && !mismatch;
               end else begin
                  idx <= idx + VEC_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_func_bist_ctrl.sv
// Bench for func_bist_ctrl: two instances (settle 1 and settle 0) beside a
// behavioural func unit with a stuck-at-0 option, checked every cycle.
module tb_func_bist_ctrl;
   import func_pkg::*;

   typedef struct {
      logic       busy;
      logic       done;
      logic       pass;
      logic [3:0] fsel;
      logic       fa;
      logic       fb;
      logic [6:0] err;
      logic       fv;
      logic [5:0] fvec;
   } exp_t;

   typedef struct {
      bit         active;
      bit         sgl;
      logic [3:0] ssel;
      bit         stuck;
      int         c;
      exp_t       held;
   } run_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       single = 1'b0;
   logic [3:0] single_sel = '0;
   logic       stuck0 = 1'b0;
   bit         cmp_en = 1'b0;

   logic [3:0] f_sel1, f_sel0;
   logic       f_a1, f_b1, f_z1, f_a0, f_b0, f_z0;
   logic       busy1, done1, pass1, fv1, busy0, done0, pass0, fv0;
   logic [6:0] err1, err0;
   logic [5:0] fvec1, fvec0;
   state_t     st1, st0;

   int errors = 0;
   int checks = 0;
   run_t m1, m0;
   logic [1:0] ab_q[$];
   logic [1:0] exp_q[$];

   always #5 clk = ~clk;

   // Behavioural func unit, optionally with its output stuck at 0.
   assign f_z1 = stuck0 ? 1'b0 : f_sel1[{f_a1, f_b1}];
   assign f_z0 = stuck0 ? 1'b0 : f_sel0[{f_a0, f_b0}];

   func_bist_ctrl #(.SETTLE_CYC(1), .ERR_W(7)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .single(single), .single_sel(single_sel),
      .f_sel(f_sel1), .f_a(f_a1), .f_b(f_b1), .f_z(f_z1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
      .fail_valid(fv1), .fail_vec(fvec1), .dbg_state(st1)
   );

   func_bist_ctrl #(.SETTLE_CYC(0), .ERR_W(7)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .single(single), .single_sel(single_sel),
      .f_sel(f_sel0), .f_a(f_a0), .f_b(f_b0), .f_z(f_z0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
      .fail_valid(fv0), .fail_vec(fvec0), .dbg_state(st0)
   );

   // ---------------- reference model ----------------
   function automatic bit golden(input logic [5:0] v);
      int s;
      int bi;
      s  = int'(v[5:2]);
      bi = 2 * int'(v[1]) + int'(v[0]);
      return ((s >> bi) & 1) == 1;
   endfunction

   function automatic logic [5:0] vec_of(input run_t r, input int k);
      if (r.sgl) return {r.ssel, k[1:0]};
      return k[5:0];
   endfunction

   // Outputs seen in the cycle after clock edge c of a run (c=0 is the start edge).
   function automatic exp_t model_out(input run_t r, input int p);
      exp_t e;
      int n, chk_n, vi;
      logic [5:0] v;
      e = r.held;
      e.busy = 1'b0;
      e.done = 1'b0;
      if (!r.active) return e;
      n = r.sgl ? 4 : 64;
      e.busy = 1'b1;
      e.done = (r.c == n * p);
      if (r.c > 0) begin
         vi = (r.c - 1) / p;
         if (vi > n - 1) vi = n - 1;
         v = vec_of(r, vi);
         e.fsel = v[5:2];
         e.fa   = v[1];
         e.fb   = v[0];
      end
      chk_n = r.c / p;
      if (chk_n > n) chk_n = n;
      e.err  = '0;
      e.fv   = 1'b0;
      e.fvec = '0;
      for (int k = 0; k < chk_n; k++) begin
         v = vec_of(r, k);
         if (r.stuck && golden(v)) begin
            e.err = e.err + 7'd1;
            if (!e.fv) begin
               e.fv   = 1'b1;
               e.fvec = v;
            end
         end
      end
      e.pass = e.done && (e.err == 0);
      return e;
   endfunction

   function automatic run_t step(input run_t r, input int p, input logic st,
                                 input logic ab, input logic sg,
                                 input logic [3:0] ss, input logic stk);
      run_t q;
      exp_t cur;
      q = r;
      if (!r.active) begin
         if (st && !ab) begin
            q.active = 1'b1;
            q.c      = 0;
            q.sgl    = sg;
            q.ssel   = ss;
            q.stuck  = stk;
         end
      end else begin
         cur = model_out(r, p);
         if (ab) begin
            q.active    = 1'b0;
            q.held      = cur;
            q.held.pass = 1'b0;
         end else if (cur.done) begin
            q.active = 1'b0;
            q.held   = cur;
         end else begin
            q.c = r.c + 1;
         end
      end
      return q;
   endfunction

   function automatic run_t run_reset();
      run_t r;
      r.active = 1'b0;
      r.sgl    = 1'b0;
      r.ssel   = '0;
      r.stuck  = 1'b0;
      r.c      = 0;
      r.held.busy = 1'b0;
      r.held.done = 1'b0;
      r.held.pass = 1'b0;
      r.held.fsel = '0;
      r.held.fa   = 1'b0;
      r.held.fb   = 1'b0;
      r.held.err  = '0;
      r.held.fv   = 1'b0;
      r.held.fvec = '0;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1 <= run_reset();
         m0 <= run_reset();
      end else begin
         m1 <= step(m1, 3, start, abort, single, single_sel, stuck0);
         m0 <= step(m0, 2, start, abort, single, single_sel, stuck0);
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic cmp_dut(input string tag, input exp_t e, input logic [3:0] fs,
                          input logic fa, input logic fb, input logic bz,
                          input logic dn, input logic ps, input logic [6:0] ec,
                          input logic fv, input logic [5:0] fvc, input state_t st);
      chk({tag, "_busy"}, 32'(bz), 32'(e.busy));
      chk({tag, "_done"}, 32'(dn), 32'(e.done));
      chk({tag, "_pass"}, 32'(ps), 32'(e.pass));
      chk({tag, "_f_sel"}, 32'(fs), 32'(e.fsel));
      chk({tag, "_f_ab"}, 32'({fa, fb}), 32'({e.fa, e.fb}));
      chk({tag, "_err_cnt"}, 32'(ec), 32'(e.err));
      chk({tag, "_fail_valid"}, 32'(fv), 32'(e.fv));
      chk({tag, "_fail_vec"}, 32'(fvc), 32'(e.fvec));
      chk({tag, "_idle_state"}, 32'(st == IDLE), 32'(!e.busy));
   endtask

   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         cmp_dut("d1", model_out(m1, 3), f_sel1, f_a1, f_b1, busy1, done1, pass1,
                 err1, fv1, fvec1, st1);
         cmp_dut("d0", model_out(m0, 2), f_sel0, f_a0, f_b0, busy0, done0, pass0,
                 err0, fv0, fvec0, st0);
      end
   end

   // ---------------- driver ----------------
   task automatic do_run(input logic sgl, input logic [3:0] ssel, input int abort_at,
                         input int restart_at, input int limit,
                         output int d1, output int d0, output int nd1,
                         output logic b_post);
      int cyc;
      d1 = -1;
      d0 = -1;
      nd1 = 0;
      b_post = 1'b1;
      ab_q.delete();
      @(negedge clk);
      single = sgl;
      single_sel = ssel;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc <= limit) begin
         if (done1) begin
            nd1++;
            if (d1 < 0) d1 = cyc;
         end
         if (done0 && d0 < 0) d0 = cyc;
         if (cyc == abort_at + 1) b_post = busy1;
         if (busy1 && cyc >= 2) begin
            if (ab_q.size() == 0 || ab_q[$] != {f_a1, f_b1}) ab_q.push_back({f_a1, f_b1});
         end
         abort = (cyc == abort_at);
         start = (cyc == restart_at);
         single = 1'($urandom);
         single_sel = 4'($urandom);
         @(negedge clk);
         cyc++;
      end
      abort = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d1, d0, nd, n, ab, rs;
      logic b_post, sg;
      logic [3:0] ss;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_done", 32'(done1), 0);
      chk("rst_f_sel", 32'(f_sel1), 0);
      chk("rst_err_cnt", 32'(err1), 0);
      chk("rst_state", 32'(st1 == IDLE), 1);
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // Full sweep, good unit.
      do_run(1'b0, 4'd0, -1, -1, 200, d1, d0, nd, b_post);
      chk("t1_done_cycle", 32'(d1), 193);
      chk("t1_done_cycle_settle0", 32'(d0), 129);
      chk("t1_pass", 32'(pass1), 1);
      chk("t1_err_cnt", 32'(err1), 0);
      chk("t1_fail_valid", 32'(fv1), 0);

      // Full sweep, z stuck at 0.
      stuck0 = 1'b1;
      do_run(1'b0, 4'd0, -1, -1, 200, d1, d0, nd, b_post);
      chk("t2_err_cnt", 32'(err1), 32);
      chk("t2_fail_valid", 32'(fv1), 1);
      chk("t2_fail_vec", 32'(fvec1), 32'h04);
      chk("t2_pass", 32'(pass1), 0);
      chk("t2_err_cnt_settle0", 32'(err0), 32);
      stuck0 = 1'b0;

      // Single-function XOR.
      do_run(1'b1, 4'd6, -1, -1, 20, d1, d0, nd, b_post);
      chk("t3_done_cycle", 32'(d1), 13);
      chk("t3_f_sel", 32'(f_sel1), 6);
      chk("t3_pass", 32'(pass1), 1);
      exp_q = '{2'b00, 2'b01, 2'b10, 2'b11};
      chk("t3_ab_count", 32'(ab_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < ab_q.size(); i++)
         chk("t3_ab_seq", 32'(ab_q[i]), 32'(exp_q[i]));

      // Abort mid-run, then a clean rerun.
      do_run(1'b0, 4'd0, 50, -1, 60, d1, d0, nd, b_post);
      chk("t4_busy_after_abort", 32'(b_post), 0);
      chk("t4_no_done", 32'(nd), 0);
      chk("t4_pass", 32'(pass1), 0);
      do_run(1'b0, 4'd0, -1, -1, 200, d1, d0, nd, b_post);
      chk("t4_rerun_done_cycle", 32'(d1), 193);
      chk("t4_rerun_pass", 32'(pass1), 1);

      // Start while busy is ignored.
      do_run(1'b0, 4'd0, -1, 20, 200, d1, d0, nd, b_post);
      chk("t5_done_cycle", 32'(d1), 193);
      chk("t5_done_count", 32'(nd), 1);

      // Asynchronous reset mid-run.
      @(negedge clk);
      single = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy1), 0);
      chk("t6_rst_f_sel", 32'(f_sel1), 0);
      chk("t6_rst_f_ab", 32'({f_a1, f_b1}), 0);
      chk("t6_rst_err_cnt", 32'(err1), 0);
      chk("t6_rst_state", 32'(st1 == IDLE), 1);
      chk("t6_rst_state_settle0", 32'(st0 == IDLE), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized runs against the model.
      for (int r = 0; r < 10; r++) begin
         sg = 1'($urandom_range(0, 1));
         ss = 4'($urandom_range(0, 15));
         stuck0 = 1'($urandom_range(0, 1));
         n = sg ? 4 : 64;
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, n * 2)) : -1;
         rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, n * 2)) : -1;
         do_run(sg, ss, ab, rs, n * 3 + 4, d1, d0, nd, b_post);
         if (ab < 0) begin
            chk("rnd_done_cycle", 32'(d1), 32'(n * 3 + 1));
            chk("rnd_done_cycle_settle0", 32'(d0), 32'(n * 2 + 1));
         end else begin
            chk("rnd_abort_no_done", 32'(nd), 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
